// File: rtl/iobuf_bus_ctrl.sv
// Bidirectional pad-bank controller: registered tri-state drive, input synchroniser,
// and a turnaround FSM that inserts released dead cycles on every direction change.
module iobuf_bus_ctrl #(
  parameter int WIDTH       = 8,
  parameter int TURNAROUND  = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  inout  wire  [WIDTH-1:0] io,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             drive_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    TURN_ON,
    DRIVE,
    TURN_OFF
  } state_t;

  localparam logic [3:0] COUNT_LOAD = (TURNAROUND > 0) ? 4'(TURNAROUND - 1) : 4'd0;
  localparam logic [2:0] FILL_FULL  = 3'(SYNC_STAGES);

  state_t           state;
  state_t           next_state;
  logic [3:0]       count;
  logic [2:0]       fill;
  logic [WIDTH-1:0] dout_r;
  logic [WIDTH-1:0] sync_r [SYNC_STAGES];
  logic             transfer;

  assign transfer = wr_req && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (transfer) begin
          next_state = (TURNAROUND > 0) ? TURN_ON : DRIVE;
        end
      end
      TURN_ON: begin
        if (count == 4'd0) begin
          next_state = DRIVE;
        end
      end
      DRIVE: begin
        if (!wr_req) begin
          next_state = (TURNAROUND > 0) ? TURN_OFF : IDLE;
        end
      end
      TURN_OFF: begin
        if (count == 4'd0) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (state == IDLE) || (state == DRIVE);
    busy     = (state != IDLE);
    rd_valid = (state == IDLE) && (fill == FILL_FULL);
  end

  // Output enable follows next_state so the pins switch cleanly on the edge itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= 4'd0;
      dout_r   <= '0;
      drive_en <= 1'b0;
      fill     <= 3'd0;
    end else begin
      drive_en <= (next_state == DRIVE);
      if (transfer) begin
        dout_r <= wr_data;
      end
      if ((state == IDLE && transfer) || (state == DRIVE && !wr_req)) begin
        count <= COUNT_LOAD;
      end else if (count != 4'd0) begin
        count <= count - 4'd1;
      end
      if (next_state != IDLE) begin
        fill <= 3'd0;
      end else if (state == IDLE && fill != FILL_FULL) begin
        fill <= fill + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= '0;
      end
    end else begin
      sync_r[0] <= io;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

  assign rd_data = sync_r[SYNC_STAGES-1];
  assign io      = drive_en ? dout_r : {WIDTH{1'bz}};

endmodule

// File: tb/tb_iobuf_bus_ctrl.sv
// Bench for iobuf_bus_ctrl: directed scenarios plus random traffic scored against a
// timeline model (session start/end edge numbers) and a history of sampled bus values.
module tb_iobuf_bus_ctrl;

  localparam int W = 8;
  localparam int T = 2;
  localparam int S = 2;
  localparam int PH_IDLE = 0;
  localparam int PH_ON = 1;
  localparam int PH_DRIVE = 2;
  localparam int PH_OFF = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         wr_req = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         ext_en = 1'b0;
  logic [W-1:0] ext_data = '0;
  wire  [W-1:0] io;
  logic         wr_ready, drive_en, rd_valid, busy;
  logic [W-1:0] rd_data;

  logic         wr_req0 = 1'b0;
  logic [W-1:0] wr_data0 = '0;
  wire  [W-1:0] io0;
  logic         wr_ready0, drive_en0, rd_valid0, busy0;
  logic [W-1:0] rd_data0;

  assign io = ext_en ? ext_data : {W{1'bz}};

  iobuf_bus_ctrl #(.WIDTH(W), .TURNAROUND(T), .SYNC_STAGES(S)) dut (
    .clk(clk), .reset(reset), .io(io), .wr_req(wr_req), .wr_data(wr_data),
    .wr_ready(wr_ready), .drive_en(drive_en), .rd_data(rd_data),
    .rd_valid(rd_valid), .busy(busy)
  );

  iobuf_bus_ctrl #(.WIDTH(W), .TURNAROUND(0), .SYNC_STAGES(S)) dut0 (
    .clk(clk), .reset(reset), .io(io0), .wr_req(wr_req0), .wr_data(wr_data0),
    .wr_ready(wr_ready0), .drive_en(drive_en0), .rd_data(rd_data0),
    .rd_valid(rd_valid0), .busy(busy0)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: edge index of the last transfer-from-idle and of the release edge.
  int           e;
  bit           m_sess;
  bit           m_ended;
  int           m_start;
  int           m_end;
  int           m_idle_since;
  logic [W-1:0] m_word;
  logic [W-1:0] hist [0:4095];
  bit           hist_ok [0:4095];

  function automatic int phase();
    if (!m_sess) return PH_IDLE;
    if (!m_ended) return (e < m_start + T) ? PH_ON : PH_DRIVE;
    return (e < m_end + T) ? PH_OFF : PH_IDLE;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit req, input logic [W-1:0] d,
                               input logic [W-1:0] ext_next);
    int pre;
    int post;
    reset   = r;
    wr_req  = req;
    wr_data = d;
    #1;
    pre = phase();
    checkOutput("wr_ready", 32'(wr_ready), 32'(pre == PH_IDLE || pre == PH_DRIVE));
    @(posedge clk);
    e++;
    if (pre == PH_DRIVE) begin
      hist[e] = m_word;
      hist_ok[e] = 1'b1;
    end else if (ext_en) begin
      hist[e] = ext_data;
      hist_ok[e] = 1'b1;
    end else begin
      hist_ok[e] = 1'b0;
    end
    if (r) begin
      m_sess = 1'b0;
      m_word = '0;
    end else if (pre == PH_IDLE && req) begin
      m_sess  = 1'b1;
      m_ended = 1'b0;
      m_start = e;
      m_word  = d;
    end else if (pre == PH_DRIVE) begin
      if (req) begin
        m_word = d;
      end else begin
        m_ended = 1'b1;
        m_end   = e;
      end
    end
    post = phase();
    if (post == PH_IDLE && (pre != PH_IDLE || r)) m_idle_since = e;
    #1;
    checkOutput("drive_en", 32'(drive_en), 32'(post == PH_DRIVE));
    checkOutput("busy", 32'(busy), 32'(post != PH_IDLE));
    checkOutput("rd_valid", 32'(rd_valid), 32'(post == PH_IDLE && (e - m_idle_since) >= S));
    if (post == PH_DRIVE) checkOutput("io_word", 32'(io), 32'(m_word));
    if (post == PH_IDLE && (e - m_idle_since) >= S && hist_ok[e-S+1])
      checkOutput("rd_data", 32'(rd_data), 32'(hist[e-S+1]));
    ext_en   = (post == PH_IDLE);
    ext_data = ext_next;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) hist_ok[i] = 1'b0;
    reset    = 1'b1;
    ext_en   = 1'b1;
    ext_data = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    e = 0;
    m_sess = 1'b0;
    m_ended = 1'b0;
    m_start = 0;
    m_end = 0;
    m_word = '0;
    m_idle_since = 0;
    checkOutput("rst_drive_en", 32'(drive_en), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("rst_rd_data", 32'(rd_data), 32'd0);

    // External 0xA5 becomes visible two edges after reset release
    applyStimulus(1'b0, 1'b0, 8'h00, 8'hA5);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'hA5);
    checkOutput("idle_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("idle_rd_a5", 32'(rd_data), 32'hA5);

    // Single write pulse
    applyStimulus(1'b0, 1'b1, 8'h3C, 8'h5E);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'(i), 8'h5E);

    // Burst 01,02,03 then read-after-write of 0x77
    applyStimulus(1'b0, 1'b1, 8'h01, 8'h77);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h02, 8'h77);
    applyStimulus(1'b0, 1'b1, 8'h03, 8'h77);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h77);
    checkOutput("raw_rd_data", 32'(rd_data), 32'h77);
    checkOutput("raw_rd_valid", 32'(rd_valid), 32'd1);

    // Reset during the second burst word, wr_req still high
    applyStimulus(1'b0, 1'b1, 8'h11, 8'h42);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h22, 8'h42);
    applyStimulus(1'b1, 1'b1, 8'h33, 8'h42);
    checkOutput("mid_rst_drive_en", 32'(drive_en), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h42);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
                    8'($urandom), 8'($urandom));
    end

    // Zero-turnaround instance: drive starts right after the transfer edge
    reset    = 1'b0;
    wr_req0  = 1'b1;
    wr_data0 = 8'h5A;
    #1;
    checkOutput("t0_wr_ready", 32'(wr_ready0), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("t0_drive_en", 32'(drive_en0), 32'd1);
    checkOutput("t0_io_5a", 32'(io0), 32'h5A);
    checkOutput("t0_busy", 32'(busy0), 32'd1);
    wr_data0 = 8'h6B;
    @(posedge clk);
    #1;
    checkOutput("t0_io_6b", 32'(io0), 32'h6B);
    wr_req0 = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("t0_release", 32'(drive_en0), 32'd0);
    checkOutput("t0_idle", 32'(busy0), 32'd0);
    checkOutput("t0_ready", 32'(wr_ready0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
